// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART blocks (tx today, rx later).
//   - uart_state_e : transmitter/receiver frame state
//   - UART_DEFAULT_CLKS_PER_BIT : default baud divisor (100 MHz / 115200)
//   - UART_PARITY_EVEN / UART_PARITY_ODD : parity mode selectors
//   - uart_parity() : parity of a payload, widest legal frame
package uart_pkg;

  localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 868;
  localparam int unsigned UART_DEFAULT_DATA_BITS    = 8;
  localparam int unsigned UART_MAX_DATA_BITS        = 9;

  localparam bit UART_PARITY_EVEN = 1'b0;
  localparam bit UART_PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Payload is zero-extended by the caller; zeros do not change the XOR.
  function automatic logic uart_parity(input logic [UART_MAX_DATA_BITS-1:0] data,
                                       input logic                          odd);
    return (^data) ^ odd;
  endfunction

endpackage : uart_pkg

// File: rtl/uart_tx_if.sv
// uart_tx_if: producer-side handshake plus serial output of the transmitter.
//   tx_data  : payload, sampled only when the frame is accepted
//   tx_valid : producer has tx_data available
//   tx_ready : transmitter is idle and can accept a frame
//   tx       : registered serial line, idles high
//   tx_busy  : a frame is in progress
// master = producer side, slave = uart_tx side.
interface uart_tx_if #(
  parameter int unsigned DATA_BITS = 8
);

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx;
  logic                 tx_busy;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx,
    input  tx_busy
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx,
    output tx_busy
  );

endinterface : uart_tx_if

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: divides clk down to one bit period.
//   clk      : clock
//   reset    : synchronous active-high reset
//   enable   : count while high; held at zero while low
//   bit_done : high during the last clk cycle of each bit period
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic bit_done
);

  localparam int unsigned           CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_wrap;

  assign w_wrap   = (r_count == CNT_LAST);
  assign bit_done = enable && w_wrap;

  // Restarting from zero whenever disabled aligns every frame to its accept edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (!enable || w_wrap) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule : uart_baud_counter

// File: rtl/uart_tx.sv
// uart_tx: 8N1-style serial transmitter with optional parity bit.
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous active-high reset; aborts any frame in flight
//   bus   : uart_tx_if.slave (tx_data/tx_valid in, tx_ready/tx/tx_busy out)
// Frame: start(0), DATA_BITS data LSB first, optional parity, stop(1);
// each bit lasts CLKS_PER_BIT cycles. tx is registered from the current
// state, so the start bit appears on the first edge after the accept edge.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = UART_DEFAULT_DATA_BITS,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = UART_PARITY_EVEN
) (
  input  logic    clk,
  input  logic    reset,
  uart_tx_if.slave bus
);

  localparam int unsigned              BIT_CNT_W = $clog2(DATA_BITS);
  localparam logic [BIT_CNT_W-1:0]     LAST_BIT  = BIT_CNT_W'(DATA_BITS - 1);

  uart_state_e          r_state;
  uart_state_e          w_next_state;

  logic [DATA_BITS-1:0] r_shift;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic                 r_parity;
  logic                 r_tx;
  logic                 r_ready;
  logic                 r_busy;

  logic                 w_accept;
  logic                 w_bit_done;
  logic                 w_load;
  logic                 w_shift;
  logic                 w_tx_next;
  logic                 w_baud_en;

  // Baud timing: runs for every state except IDLE.
  assign w_baud_en = (r_state != ST_IDLE);

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .enable   (w_baud_en),
    .bit_done (w_bit_done)
  );

  // r_ready is only ever set in IDLE, so it doubles as the IDLE qualifier.
  assign w_accept = bus.tx_valid && r_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, datapath strobes and next serial level.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_tx_next    = 1'b1;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_START;
          w_load       = 1'b1;
        end
      end

      ST_START: begin
        w_tx_next = 1'b0;
        if (w_bit_done) begin
          w_next_state = ST_DATA;
        end
      end

      ST_DATA: begin
        w_tx_next = r_shift[0];
        if (w_bit_done) begin
          w_shift = 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            w_next_state = PARITY_EN ? ST_PARITY : ST_STOP;
          end
        end
      end

      ST_PARITY: begin
        w_tx_next = r_parity;
        if (w_bit_done) begin
          w_next_state = ST_STOP;
        end
      end

      ST_STOP: begin
        w_tx_next = 1'b1;
        if (w_bit_done) begin
          w_next_state = ST_IDLE;
        end
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Shift register, bit counter and latched parity.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
    end else if (w_load) begin
      r_shift   <= bus.tx_data;
      r_bit_cnt <= '0;
      r_parity  <= uart_parity(UART_MAX_DATA_BITS'(bus.tx_data), PARITY_ODD);
    end else if (w_shift) begin
      r_shift   <= r_shift >> 1;
      r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + BIT_CNT_W'(1);
    end
  end

  // Registered outputs; ready/busy track the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx    <= 1'b1;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_tx    <= w_tx_next;
      r_ready <= (w_next_state == ST_IDLE);
      r_busy  <= (w_next_state != ST_IDLE);
    end
  end

  assign bus.tx       = r_tx;
  assign bus.tx_ready = r_ready;
  assign bus.tx_busy  = r_busy;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three transmitters (no parity, even, odd) share one stimulus.
// Outputs are sampled on the falling edge; cycle index c counts falling
// edges after the accept edge, so tx shows bit (c-1)/4 for c >= 1.
module tb_uart_tx;

  localparam int unsigned CPB      = 4;
  localparam int unsigned NB       = 8;
  localparam int          FRAME_NP = 40;
  localparam int          FRAME_P  = 44;
  localparam int          NVEC     = 6;

  typedef struct {
    logic [7:0] data;
    logic       par_even;
    logic       par_odd;
    bit         disturb;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] r_data;
  logic       r_valid;

  int n_vec = 0;
  int n_err = 0;

  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  uart_tx_if #(.DATA_BITS(NB)) if_np ();
  uart_tx_if #(.DATA_BITS(NB)) if_ev ();
  uart_tx_if #(.DATA_BITS(NB)) if_od ();

  assign if_np.tx_data  = r_data;
  assign if_np.tx_valid = r_valid;
  assign if_ev.tx_data  = r_data;
  assign if_ev.tx_valid = r_valid;
  assign if_od.tx_data  = r_data;
  assign if_od.tx_valid = r_valid;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(NB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0))
    u_np (.clk(clk), .reset(reset), .bus(if_np));
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(NB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0))
    u_ev (.clk(clk), .reset(reset), .bus(if_ev));
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(NB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1))
    u_od (.clk(clk), .reset(reset), .bus(if_od));

  // Expected serial level k falling edges after the accept edge.
  function automatic logic exp_tx(input logic [7:0] data, input bit pen,
                                  input logic par, input int k);
    int b;
    if (k < 1) return 1'b1;
    b = (k - 1) / int'(CPB);
    if (b == 0) return 1'b0;
    if (b <= int'(NB)) return data[b-1];
    if (pen && b == int'(NB) + 1) return par;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input int cyc, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @c=%0d: got %b, want %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_all_idle(input string tag, input int cyc, input logic rdy);
    chk({tag, "_np_tx"},   cyc, if_np.tx,       1'b1);
    chk({tag, "_ev_tx"},   cyc, if_ev.tx,       1'b1);
    chk({tag, "_od_tx"},   cyc, if_od.tx,       1'b1);
    chk({tag, "_np_busy"}, cyc, if_np.tx_busy,  1'b0);
    chk({tag, "_ev_busy"}, cyc, if_ev.tx_busy,  1'b0);
    chk({tag, "_od_busy"}, cyc, if_od.tx_busy,  1'b0);
    chk({tag, "_np_rdy"},  cyc, if_np.tx_ready, rdy);
    chk({tag, "_ev_rdy"},  cyc, if_ev.tx_ready, rdy);
    chk({tag, "_od_rdy"},  cyc, if_od.tx_ready, rdy);
  endtask

  // One frame on all three DUTs; data is inverted right after accept.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk_all_idle("pre", -1, 1'b1);
    r_data  = v.data;
    r_valid = 1'b1;
    @(posedge clk);
    #1;
    r_valid = 1'b0;
    r_data  = ~v.data;
    for (int c = 0; c <= FRAME_P + 1; c++) begin
      @(negedge clk);
      chk("np_tx",   c, if_np.tx,       exp_tx(v.data, 1'b0, 1'b0, c));
      chk("ev_tx",   c, if_ev.tx,       exp_tx(v.data, 1'b1, v.par_even, c));
      chk("od_tx",   c, if_od.tx,       exp_tx(v.data, 1'b1, v.par_odd, c));
      chk("np_rdy",  c, if_np.tx_ready, c >= FRAME_NP);
      chk("np_busy", c, if_np.tx_busy,  c <  FRAME_NP);
      chk("ev_rdy",  c, if_ev.tx_ready, c >= FRAME_P);
      chk("od_busy", c, if_od.tx_busy,  c <  FRAME_P);
      if (v.disturb && c == 10) begin
        r_data  = 8'h3C;
        r_valid = 1'b1;
      end
      if (v.disturb && c == 12) r_valid = 1'b0;
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h5A, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{8'h80, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 1'b0, 1'b1, 1'b1};

    // Reset: line idle, not busy, not ready while held.
    reset   = 1'b1;
    r_valid = 1'b0;
    r_data  = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_all_idle("rst", i, 1'b0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk_all_idle("rel", 0, 1'b1);

    // Table-driven frames.
    for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

    // Back-to-back: valid held across 0x00 then 0xFF.
    @(negedge clk);
    r_data  = 8'h00;
    r_valid = 1'b1;
    @(posedge clk);
    #1;
    r_data = 8'hFF;
    for (int c = 0; c <= 85; c++) begin
      @(negedge clk);
      chk("b2b_np_tx", c, if_np.tx,
          (c <= FRAME_NP + 1) ? exp_tx(8'h00, 1'b0, 1'b0, c)
                              : exp_tx(8'hFF, 1'b0, 1'b0, c - (FRAME_NP + 1)));
      chk("b2b_np_rdy", c, if_np.tx_ready, (c == FRAME_NP) || (c >= 2 * FRAME_NP + 1));
      chk("b2b_ev_tx",  c, if_ev.tx, exp_tx(8'h00, 1'b1, 1'b0, c));
      chk("b2b_od_tx",  c, if_od.tx, exp_tx(8'h00, 1'b1, 1'b1, c));
      if (c == FRAME_NP + 1) r_valid = 1'b0;
    end

    // Reset during data bit 3 of 0x5A aborts the frame for good.
    @(negedge clk);
    r_data  = 8'h5A;
    r_valid = 1'b1;
    @(posedge clk);
    #1;
    r_valid = 1'b0;
    for (int c = 0; c <= 18; c++) begin
      @(negedge clk);
      chk("abort_np_tx", c, if_np.tx, exp_tx(8'h5A, 1'b0, 1'b0, c));
      chk("abort_ev_tx", c, if_ev.tx, exp_tx(8'h5A, 1'b1, 1'b0, c));
    end
    reset = 1'b1;
    @(negedge clk);
    chk_all_idle("abort_rst", 19, 1'b0);
    reset = 1'b0;
    for (int c = 20; c <= 70; c++) begin
      @(negedge clk);
      chk_all_idle("abort_post", c, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_uart_tx

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The parameter CLKS_PER_BIT SHALL default to 868 and set clk cycles per serial bit; legal range is 2 or more.
REQ-002 The parameter DATA_BITS SHALL default to 8 and set payload bits per frame; legal range is 5 to 9.
REQ-003 The parameter PARITY_EN SHALL default to 0; 1 inserts a parity bit after the data bits.
REQ-004 The parameter PARITY_ODD SHALL default to 0 (even parity); 1 selects odd parity; it is ignored when PARITY_EN=0.
REQ-005 clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 reset SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-007 tx_data SHALL be an input, DATA_BITS wide: the payload, sampled only on accept.
REQ-008 tx_valid SHALL be an input, 1 bit: the producer has tx_data available.
REQ-009 tx_ready SHALL be an output, 1 bit: the block can accept a frame.
REQ-010 tx SHALL be an output, 1 bit: the registered serial line; idle level is 1.
REQ-011 tx_busy SHALL be an output, 1 bit: a frame is in progress (any state other than IDLE).

Function
REQ-012 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP; PARITY is entered only when PARITY_EN=1.
REQ-013 Accept SHALL occur on a clock edge where tx_valid=1, tx_ready=1 and reset=0; on accept, tx_data is latched into a shift register and the FSM moves IDLE->START.
REQ-014 tx_ready SHALL be 1 only in IDLE; tx_valid outside IDLE is ignored, and no data is queued.
REQ-015 Each of the START, DATA-bit, PARITY and STOP phases SHALL hold tx for exactly CLKS_PER_BIT cycles; tx changes only on bit boundaries.
REQ-016 The start bit SHALL be 0; data bits are sent LSB first; the stop bit is 1 (one stop bit).
REQ-017 Even parity SHALL equal the XOR of all latched data bits; odd parity is its inverse.
REQ-018 The bit counter SHALL count 0..DATA_BITS-1; DATA exits to PARITY or STOP after bit DATA_BITS-1.
REQ-019 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, and wrap to 0 on each bit boundary.
REQ-020 STOP SHALL return to IDLE after its final cycle; the minimum frame period is 1 + (2 + DATA_BITS + PARITY_EN) * CLKS_PER_BIT cycles, with tx held at 1 in the IDLE cycle.
REQ-021 Changes on tx_data after accept SHALL NOT affect the frame in flight.
REQ-022 tx SHALL go to 0 on the first edge after accept, giving a latency of 1 cycle from accept to the start bit.

Reset
REQ-023 On any clock edge with reset=1, the block SHALL force state=IDLE, tx=1, tx_busy=0, and clear the baud counter, bit counter and shift register.
REQ-024 tx_ready SHALL be 0 while reset=1 and 1 on the first cycle after reset deasserts.
REQ-025 Reset asserted mid-frame SHALL abort the frame at the next edge; after release, no remainder of the frame is transmitted.

Structure
REQ-026 Shared package uart_pkg SHALL hold the FSM state typedef, the default CLKS_PER_BIT constant and the parity-mode constants, for reuse by a future uart_rx.
REQ-027 The baud counter SHALL be a separate sub-module, uart_baud_counter, with clk, reset, enable and a bit_done pulse output; the FSM, shift register and parity logic remain in uart_tx.

Verification (bench uses CLKS_PER_BIT=4, DATA_BITS=8)
REQ-028 Reset -> tx=1, tx_busy=0 during reset; tx_ready=1 on the first cycle after release.
REQ-029 Send 0xA5 with PARITY_EN=0 -> tx = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles; tx_ready returns after 40 cycles.
REQ-030 Send 0x07 with PARITY_EN=1 -> parity bit 1 when PARITY_ODD=0 and 0 when PARITY_ODD=1; frame length is 44 cycles.
REQ-031 Hold tx_valid with 0x00 then 0xFF -> the second start bit begins exactly 1 cycle after the first stop bit ends; the second frame's data bits are all 1.
REQ-032 Assert reset during data bit 3 of 0x5A -> tx=1 at the next edge; after release, tx stays 1 and tx_ready=1 with no further low levels.
REQ-033 Change tx_data and pulse tx_valid while tx_busy=1 -> the serial output still matches the originally latched byte, and no second frame starts.
